// File: rtl/defines.sv
// defines: shared bus types, opcodes, fetch FSM encodings and immediate decoders for the core
package defines;
  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;
  typedef logic [5:0] StallBus;
  localparam InstBus ZeroWord = 32'h0;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {IDLE, MISS, DRAIN} fetch_state_t;
  function automatic InstAddrBus j_imm(input InstBus i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic InstAddrBus b_imm(input InstBus i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped one-word-line instruction cache; arrays exist only when ICACHE_EN is defined
module if_icache import defines::*; #(
  parameter int ENTRIES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] i_addr,
  input  logic        i_we,
  input  InstBus      i_wr_data,
  output logic        o_hit,
  output InstBus      o_data
);
`ifdef ICACHE_EN
  localparam int IW = $clog2(ENTRIES);
  logic [ENTRIES-1:0] r_valid;
  logic [29-IW:0] r_tag [ENTRIES];
  InstBus r_data [ENTRIES];
  logic [IW-1:0] w_idx;
  assign w_idx = i_addr[IW+1:2];
  assign o_hit = r_valid[w_idx] && r_tag[w_idx] == i_addr[31:IW+2];
  assign o_data = r_data[w_idx];
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_we) r_valid[w_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_idx] <= i_addr[31:IW+2];
      r_data[w_idx] <= i_wr_data;
    end
  end
`else
  assign o_hit = 1'b0;
  assign o_data = ZeroWord;
`endif
endmodule

// File: rtl/if_fetch.sv
// if_fetch: IF stage with hold buffer, miss FSM and static branch prediction.
// The instruction cache is built only when ICACHE_EN is defined.
module if_fetch import defines::*; #(
  parameter int ICACHE_ENTRIES = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  StallBus    stall_sign,
  input  logic       ex_jump,
  input  InstAddrBus ex_jump_target,
  output logic       if_stall_req,
  output InstAddrBus if_pc,
  output InstBus     if_inst,
  output logic       if_taken,
  output logic       mem_rd_req,
  output InstAddrBus mem_rd_addr,
  input  InstBus     mem_rd_data,
  input  logic       mem_rd_done
);
  fetch_state_t r_state;
  InstAddrBus r_pc, w_next_pc;
  InstBus r_hold_inst, w_cache_data;
  logic r_hold_valid, w_hit, w_done, w_bypass, w_fill, w_avail, w_adv;
  // rdy low hides the completion pulse; the controller re-presents it later
  assign w_done = mem_rd_done && rdy;
  assign w_bypass = r_state == MISS && w_done;
  assign w_fill = w_bypass && !ex_jump;
  assign w_avail = r_hold_valid || w_hit || w_bypass;
  assign w_adv = w_avail && !stall_sign[0];
  if_icache #(.ENTRIES(ICACHE_ENTRIES)) u_icache (
    .clk(clk), .rst(rst), .i_addr(r_pc[31:2]), .i_we(w_fill),
    .i_wr_data(mem_rd_data), .o_hit(w_hit), .o_data(w_cache_data)
  );
  always_comb begin
    if_inst = r_hold_valid ? r_hold_inst : w_hit ? w_cache_data : w_bypass ? mem_rd_data : ZeroWord;
    if_taken = if_inst[6:0] == OP_JAL || (if_inst[6:0] == OP_BRANCH && if_inst[31]);
    w_next_pc = r_pc + (if_inst[6:0] == OP_JAL ? j_imm(if_inst) : if_taken ? b_imm(if_inst) : 32'd4);
  end
  assign if_stall_req = !w_avail;
  assign if_pc = r_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= ZeroWord;
      r_state <= IDLE;
      r_hold_valid <= 1'b0;
      r_hold_inst <= ZeroWord;
      mem_rd_req <= 1'b0;
      mem_rd_addr <= ZeroWord;
    end else if (rdy) begin
      if (ex_jump) r_pc <= ex_jump_target;
      else if (w_adv) r_pc <= w_next_pc;
      if (ex_jump || w_adv) r_hold_valid <= 1'b0;
      else if (w_fill) begin
        r_hold_valid <= 1'b1;
        r_hold_inst <= mem_rd_data;
      end
      case (r_state)
        IDLE: if (!w_avail && !ex_jump) begin
          mem_rd_req <= 1'b1;
          mem_rd_addr <= r_pc;
          r_state <= MISS;
        end
        MISS: if (w_done) begin
          mem_rd_req <= 1'b0;
          r_state <= IDLE;
        end else if (ex_jump) r_state <= DRAIN;
        DRAIN: if (w_done) begin
          mem_rd_req <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a fixed-latency memory responder
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst, rdy, ex_jump, if_stall_req, if_taken, mem_rd_req, mem_rd_done;
  logic [5:0] stall_sign;
  logic [31:0] ex_jump_target, if_pc, if_inst, mem_rd_addr, mem_rd_data, last_addr;
  int n_cmp = 0, n_err = 0, n_req = 0, cnt = 0, n0, lat;
  always #5 clk = ~clk;
  if_fetch #(.ICACHE_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall_sign), .ex_jump(ex_jump),
    .ex_jump_target(ex_jump_target), .if_stall_req(if_stall_req), .if_pc(if_pc),
    .if_inst(if_inst), .if_taken(if_taken), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_rd_done(mem_rd_done)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0C: return 32'hFE000AE3;
      32'h40: return 32'h0800006F;
      default: return 32'h00000013;
    endcase
  endfunction
  // memory controller: done pulse 3 cycles after the request, frozen while rdy is low
  initial begin
    mem_rd_done = 1'b0;
    mem_rd_data = 32'h0;
    last_addr = 32'h0;
  end
  always @(negedge clk) begin
    if (rst) begin
      mem_rd_done = 1'b0;
      cnt = 0;
    end else if (rdy) begin
      if (mem_rd_done) mem_rd_done = 1'b0;
      else if (mem_rd_req) begin
        if (cnt == 0) begin
          n_req++;
          last_addr = mem_rd_addr;
        end
        cnt++;
        if (cnt == 3) begin
          mem_rd_done = 1'b1;
          mem_rd_data = mem_word(mem_rd_addr);
          cnt = 0;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic wait_inst(input string tag, output int n);
    n = 0;
    while (if_stall_req && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'b0, if_stall_req}, 32'd0);
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!mem_rd_done && k < 20) begin
      step();
      k++;
    end
    chk(tag, {31'b0, mem_rd_done}, 32'd1);
  endtask
  task automatic jump(input logic [31:0] t);
    ex_jump = 1'b1;
    ex_jump_target = t;
    step();
    ex_jump = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; stall_sign = '0; ex_jump = 1'b0; ex_jump_target = '0;
    step(); step();
    chk("rst_stall", {31'b0, if_stall_req}, 1);
    chk("rst_inst", if_inst, 0);
    chk("rst_taken", {31'b0, if_taken}, 0);
    chk("rst_req", {31'b0, mem_rd_req}, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_pc", if_pc, 0);
    rst = 1'b0;
    step();
    chk("miss_req", {31'b0, mem_rd_req}, 1);
    chk("miss_addr", mem_rd_addr, 0);
    wait_inst("miss_to", lat);
    chk("miss_lat", lat, 2);
    chk("nop_pc", if_pc, 0);
    chk("nop_inst", if_inst, 32'h13);
    chk("nop_taken", {31'b0, if_taken}, 0);
    step();
    chk("nop_next", if_pc, 4);
    for (int i = 1; i < 3; i++) begin
      wait_inst("loop_to", lat);
      chk("loop_pc", if_pc, i * 4);
      chk("loop_inst", if_inst, 32'h13);
      step();
    end
    wait_inst("beq_to", lat);
    chk("beq_inst", if_inst, 32'hFE000AE3);
    chk("beq_taken", {31'b0, if_taken}, 1);
    step();
    chk("beq_target", if_pc, 0);
    chk("loop_reqs", n_req, 4);
`ifdef ICACHE_EN
    for (int i = 0; i < 4; i++) begin
      chk("hit_stall", {31'b0, if_stall_req}, 0);
      chk("hit_pc", if_pc, i * 4);
      step();
    end
    chk("hit_noreq", n_req, 4);
`endif
    jump(32'h20);
    chk("j20_pc", if_pc, 32'h20);
    step();
    chk("d_req", {31'b0, mem_rd_req}, 1);
    chk("d_addr", mem_rd_addr, 32'h20);
    jump(32'h100);
    chk("d_pc", if_pc, 32'h100);
    chk("d_held", {31'b0, mem_rd_req}, 1);
    chk("d_addr_held", mem_rd_addr, 32'h20);
    wait_done("d_done_to");
    chk("d_nobypass", {31'b0, if_stall_req}, 1);
    step();
    chk("d_idle", {31'b0, mem_rd_req}, 0);
    step();
    chk("d_newreq", {31'b0, mem_rd_req}, 1);
    chk("d_newaddr", last_addr, 32'h100);
    n0 = n_req;
    stall_sign = 6'b1;
    wait_done("h_done_to");
    chk("h_bypass", if_inst, 32'h13);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("h_stall", {31'b0, if_stall_req}, 0);
      chk("h_inst", if_inst, 32'h13);
      chk("h_pc", if_pc, 32'h100);
      chk("h_noreq", {31'b0, mem_rd_req}, 0);
    end
    stall_sign = 6'b0;
    step();
    chk("h_adv", if_pc, 32'h104);
    chk("h_reqcnt", n_req, n0);
    jump(32'h20);
    chk("d_nocache", {31'b0, if_stall_req}, 1);
    jump(32'h40);
    wait_inst("jal_to", lat);
    chk("jal_inst", if_inst, 32'h0800006F);
    chk("jal_taken", {31'b0, if_taken}, 1);
    step();
    chk("jal_target", if_pc, 32'hC0);
    step();
    chk("r_req", {31'b0, mem_rd_req}, 1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_pc", if_pc, 32'hC0);
      chk("r_held", {31'b0, mem_rd_req}, 1);
      chk("r_addr", mem_rd_addr, 32'hC0);
      chk("r_stall", {31'b0, if_stall_req}, 1);
      chk("r_inst", if_inst, 0);
    end
    rdy = 1'b1;
    wait_done("r_done_to");
    rdy = 1'b0;
    step();
    chk("rm_pc", if_pc, 32'hC0);
    chk("rm_miss", {31'b0, mem_rd_req}, 1);
    rdy = 1'b1;
    #1;
    chk("rm_inst", if_inst, 32'h13);
    step();
    chk("rm_adv", if_pc, 32'hC4);
    chk("rm_idle", {31'b0, mem_rd_req}, 0);
    step();
    wait_done("jd_done_to");
    jump(32'h200);
    chk("jd_pc", if_pc, 32'h200);
    chk("jd_idle", {31'b0, mem_rd_req}, 0);
    step();
    chk("jd_req", {31'b0, mem_rd_req}, 1);
    chk("jd_addr", mem_rd_addr, 32'h200);
    rst = 1'b1;
    step();
    chk("mr_req", {31'b0, mem_rd_req}, 0);
    chk("mr_pc", if_pc, 0);
    chk("mr_stall", {31'b0, if_stall_req}, 1);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
